// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose:
//   Multi-cycle control unit for the 8-bit core. Accepts one instruction per
//   ready/valid handshake and steps it through FETCH, DECODE, EXEC, MEM and
//   WB. Datapath strobes are Moore outputs, decoded from the state register
//   and the opcode/func latched at the handshake. An instruction waits in MEM
//   until the data memory reports completion. Undefined encodings raise a
//   one-cycle illegal pulse in DECODE and return to FETCH without retiring.
//
// Optional feature (compile-time macro):
//   CU_PERF_CNT_EN - adds the instr_count output, a CNT_W-bit wrapping count
//                    of retired instructions. Without the macro, the port and
//                    the counter are absent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   fetch side presents an instruction
//   instr_ready  out  unit accepts an instruction (FETCH only)
//   opcode       in   opcode, sampled on the handshake
//   func         in   R-type function field, sampled on the handshake
//   mem_ready    in   data memory finished the current access (MEM only)
//   RegWrite     out  register file write strobe
//   AluSrc       out  0 = register operand, 1 = immediate
//   AluControl   out  ALU operation select
//   MemWrite     out  data memory write strobe
//   MemtoReg     out  writeback source is memory
//   jump         out  PC load strobe
//   r2Chooser    out  second read port selects the rd/source field
//   retire       out  one-cycle pulse as an instruction completes
//   illegal      out  one-cycle pulse on an undefined encoding
//   instr_count  out  retired-instruction count (CU_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W  = 4,
  parameter int FUNC_W    = 3,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNC_W-1:0]    func,
  input  logic                 mem_ready,
  output logic                 RegWrite,
  output logic                 AluSrc,
  output logic [ALUCTRL_W-1:0] AluControl,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 jump,
  output logic                 r2Chooser,
  output logic                 retire,
  output logic                 illegal
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction class of the latched encoding; K_BAD covers every
  // undefined encoding.
  typedef enum logic [2:0] {
    K_R    = 3'd0,
    K_ADDI = 3'd1,
    K_LW   = 3'd2,
    K_SW   = 3'd3,
    K_CMP  = 3'd4,
    K_JMP  = 3'd5,
    K_BAD  = 3'd6
  } kind_t;

  localparam logic [OPCODE_W-1:0]  OP_R    = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0]  OP_ADDI = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0]  OP_LW   = OPCODE_W'(4'b1011);
  localparam logic [OPCODE_W-1:0]  OP_SW   = OPCODE_W'(4'b1111);
  localparam logic [OPCODE_W-1:0]  OP_CMP  = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0]  OP_JMP  = OPCODE_W'(4'b0010);
  // The all-ones function code is not an R-type operation.
  localparam logic [FUNC_W-1:0]    FUNC_ILL = {FUNC_W{1'b1}};
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = '0;
  localparam logic [ALUCTRL_W-1:0] ALU_CMP  = ALUCTRL_W'(3'b111);

  state_t              state_q, state_d;
  logic                run_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic [FUNC_W-1:0]   func_q;
  kind_t               kind;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                alu_src;

  // ------------------------------------------------------------------------
  // State and instruction registers
  // ------------------------------------------------------------------------
  // run_q keeps instr_ready low while reset is held and rises on the first
  // clock after release, so the fetch side never sees ready during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      run_q    <= 1'b0;
      opcode_q <= '0;
      func_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == S_FETCH && run_q && instr_valid) begin
        opcode_q <= opcode;
        func_q   <= func;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Instruction classification of the latched encoding
  // ------------------------------------------------------------------------
  always_comb begin
    kind = K_BAD;
    case (opcode_q)
      OP_R:    kind = (func_q == FUNC_ILL) ? K_BAD : K_R;
      OP_ADDI: kind = K_ADDI;
      OP_LW:   kind = K_LW;
      OP_SW:   kind = K_SW;
      OP_CMP:  kind = K_CMP;
      OP_JMP:  kind = K_JMP;
      default: kind = K_BAD;
    endcase
  end

  // ALU controls set up in EXEC and held through MEM and WB so the datapath
  // result stays stable until it is written back.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    case (kind)
      K_R:                 alu_ctrl = ALUCTRL_W'(func_q);
      K_ADDI, K_LW, K_SW:  alu_src  = 1'b1;
      K_CMP:               alu_ctrl = ALU_CMP;
      K_JMP:               alu_src  = 1'b1;
      default: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Next-state and Moore output decode
  // ------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    RegWrite    = 1'b0;
    AluSrc      = 1'b0;
    AluControl  = '0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    jump        = 1'b0;
    r2Chooser   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        instr_ready = run_q;
        if (run_q && instr_valid) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (kind == K_BAD) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        AluControl = alu_ctrl;
        AluSrc     = alu_src;
        r2Chooser  = (kind == K_SW) || (kind == K_CMP);
        jump       = (kind == K_JMP);
        case (kind)
          K_R, K_ADDI: state_d = S_WB;
          K_LW, K_SW:  state_d = S_MEM;
          K_CMP, K_JMP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default:     state_d = S_FETCH;
        endcase
      end

      // No timeout: a memory that never answers holds the unit here.
      S_MEM: begin
        AluControl = alu_ctrl;
        AluSrc     = alu_src;
        if (kind == K_SW) begin
          MemWrite  = 1'b1;
          r2Chooser = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          MemtoReg = 1'b1;
          if (mem_ready) begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        AluControl = alu_ctrl;
        AluSrc     = alu_src;
        RegWrite   = 1'b1;
        MemtoReg   = (kind == K_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

`ifdef CU_PERF_CNT_EN
  // ------------------------------------------------------------------------
  // Retired-instruction counter (wraps naturally at 2^CNT_W)
  // ------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;

  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`else
  // CNT_W only sizes the optional counter.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] func = 3'd0;
  logic       instr_ready, RegWrite, AluSrc, MemWrite, MemtoReg;
  logic       jump, r2Chooser, retire, illegal;
  logic [2:0] AluControl;
`ifdef CU_PERF_CNT_EN
  logic [3:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(4), .FUNC_W(3), .ALUCTRL_W(3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .AluSrc(AluSrc), .AluControl(AluControl),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .jump(jump),
    .r2Chooser(r2Chooser), .retire(retire), .illegal(illegal)
`ifdef CU_PERF_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic       rdy;
    logic       rw;
    logic       asrc;
    logic [2:0] alu;
    logic       mw;
    logic       m2r;
    logic       jmp;
    logic       r2;
    logic       ret;
    logic       ill;
  } obs_t;

  typedef struct {
    obs_t o;
    logic in_mem;
    logic mr;
  } step_t;

  function automatic obs_t sample();
    obs_t s;
    s.rdy  = instr_ready;
    s.rw   = RegWrite;
    s.asrc = AluSrc;
    s.alu  = AluControl;
    s.mw   = MemWrite;
    s.m2r  = MemtoReg;
    s.jmp  = jump;
    s.r2   = r2Chooser;
    s.ret  = retire;
    s.ill  = illegal;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the expected per-cycle output trace of one instruction from the
  // instruction-level rules, drives it, and checks every cycle plus the
  // handshake-to-retire latency.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input int w);
    step_t tr[$];
    step_t st;
    obs_t  z, e, m, f, s;
    int    k, exp_lat, obs_lat;

    z = '0;
    f = '0;
    f.rdy = 1'b1;
    if (op == 4'b0000 && fn != 3'b111) k = 0;
    else if (op == 4'b0100) k = 1;
    else if (op == 4'b1011) k = 2;
    else if (op == 4'b1111) k = 3;
    else if (op == 4'b1000) k = 4;
    else if (op == 4'b0010) k = 5;
    else k = -1;

    st.in_mem = 1'b0;
    st.mr = 1'b0;
    st.o = z;
    st.o.ill = (k < 0);
    tr.push_back(st);
    if (k >= 0) begin
      e = z;
      case (k)
        0: e.alu = fn;
        1, 2: e.asrc = 1'b1;
        3: begin e.asrc = 1'b1; e.r2 = 1'b1; end
        4: begin e.alu = 3'b111; e.r2 = 1'b1; e.ret = 1'b1; end
        default: begin e.asrc = 1'b1; e.jmp = 1'b1; e.ret = 1'b1; end
      endcase
      st.o = e;
      tr.push_back(st);
      if (k == 2 || k == 3) begin
        m = e;
        if (k == 3) m.mw = 1'b1;
        else m.m2r = 1'b1;
        st.in_mem = 1'b1;
        st.mr = 1'b0;
        st.o = m;
        for (int j = 0; j < w; j++) tr.push_back(st);
        if (k == 3) m.ret = 1'b1;
        st.o = m;
        st.mr = 1'b1;
        tr.push_back(st);
        st.in_mem = 1'b0;
      end
      if (k <= 2) begin
        m = e;
        m.rw = 1'b1;
        m.m2r = (k == 2);
        m.ret = 1'b1;
        st.o = m;
        tr.push_back(st);
      end
    end

    if (k < 0) exp_lat = 0;
    else if (k <= 1) exp_lat = 3;
    else if (k == 2) exp_lat = 4 + w;
    else if (k == 3) exp_lat = 3 + w;
    else exp_lat = 2;

    instr_valid = 1'b1;
    opcode = op;
    func = fn;
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk($sformatf("fetch op%h", op), 32'(sample()), 32'(f));
`ifdef CU_PERF_CNT_EN
    chk("instr_count", 32'(instr_count), 32'(model_count % 16));
`endif
    @(posedge clk);
    #1;
    obs_lat = 0;
    foreach (tr[i]) begin
      instr_valid = 1'($urandom);
      opcode = 4'($urandom);
      func = 3'($urandom);
      mem_ready = tr[i].in_mem ? tr[i].mr : 1'($urandom);
      @(negedge clk);
      s = sample();
      if (s.ret && obs_lat == 0) obs_lat = i + 1;
      chk($sformatf("op%h fn%h cyc%0d", op, fn, i + 1), 32'(s), 32'(tr[i].o));
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    chk($sformatf("latency op%h", op), 32'(obs_lat), 32'(exp_lat));
    if (k >= 0) model_count++;
  endtask

  logic [3:0] ill_ops [10];
  logic [3:0] rop;
  logic [2:0] rfn;
  obs_t       f0;

  initial begin
    ill_ops = '{4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
    f0 = '0;
    f0.rdy = 1'b1;

    // Reset state and ready rising after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 32'(sample()), 32'd0);
`ifdef CU_PERF_CNT_EN
    chk("reset count", 32'(instr_count), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("ready before first edge", 32'(instr_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready after release", 32'(sample()), 32'(f0));

    // Directed sequence
    run_instr(4'b0000, 3'b010, 0);
    run_instr(4'b1011, 3'b000, 5);
    run_instr(4'b1111, 3'b101, 1);
    run_instr(4'b0000, 3'b111, 0);
    run_instr(4'b0101, 3'b000, 0);
    run_instr(4'b0010, 3'b000, 0);
    run_instr(4'b1000, 3'b011, 0);

    // Asynchronous reset while SW is waiting in MEM
    instr_valid = 1'b1;
    opcode = 4'b1111;
    func = 3'b000;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sw memwrite in mem", 32'(MemWrite), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset strobes", 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_count = 0;
    @(posedge clk);
    #1;
    chk("fetch after reset", 32'(sample()), 32'(f0));

    // Counter wrap: 17 ADDI retirements with illegal encodings in between
    for (int i = 0; i < 17; i++) begin
      run_instr(4'b0100, 3'($urandom), 0);
      if (i % 4 == 1) run_instr(ill_ops[$urandom_range(0, 9)], 3'($urandom), 0);
    end
`ifdef CU_PERF_CNT_EN
    @(negedge clk);
    chk("count wrap", 32'(instr_count), 32'd1);
    @(posedge clk);
    #1;
`endif

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      rfn = 3'($urandom);
      case ($urandom_range(0, 7))
        0: begin rop = 4'b0000; rfn = 3'($urandom_range(0, 6)); end
        1: rop = 4'b0100;
        2: rop = 4'b1011;
        3: rop = 4'b1111;
        4: rop = 4'b1000;
        5: rop = 4'b0010;
        6: begin rop = 4'b0000; rfn = 3'b111; end
        default: rop = ill_ops[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 3) == 0) begin
        instr_valid = 1'b0;
        @(negedge clk);
        chk("idle fetch", 32'(sample()), 32'(f0));
        @(posedge clk);
        #1;
      end
      run_instr(rop, rfn, $urandom_range(0, 3));
    end

    @(negedge clk);
    chk("final fetch", 32'(sample()), 32'(f0));
`ifdef CU_PERF_CNT_EN
    chk("final count", 32'(instr_count), 32'(model_count % 16));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
